// File: rtl/clk_gen_multi.sv
// clk_gen_multi: NUM_CH independent programmable clock dividers with shadowed half-period updates.
// Optional feature: define CLK_GEN_SYNC_EN to add sync_restart, which phase-aligns all channels.
module clk_gen_multi #(
    parameter int NUM_CH = 2,
    parameter int WIDTH = 16,
    parameter logic [WIDTH-1:0] DEFAULT_HALF = '0,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    input  logic [CW-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]  cfg_half,
`ifdef CLK_GEN_SYNC_EN
    input  logic              sync_restart,
`endif
    output logic              cfg_ready,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);
    logic [WIDTH-1:0]  r_cnt    [NUM_CH];
    logic [WIDTH-1:0]  r_half   [NUM_CH];
    logic [WIDTH-1:0]  r_shadow [NUM_CH];
    logic [NUM_CH-1:0] r_clk, r_tick, r_pend;
    logic [NUM_CH-1:0] w_run, w_tgl, w_bnd, w_acc;
    logic              w_ready, w_sync;
`ifdef CLK_GEN_SYNC_EN
    assign w_sync = sync_restart;
`else
    assign w_sync = 1'b0;
`endif
    // Handshake decode plus per-channel toggle and update-boundary detection
    always_comb begin
        w_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++)
            w_ready = (cfg_ch == CW'(i)) ? ~r_pend[i] : w_ready;
        for (int i = 0; i < NUM_CH; i++) begin
            w_run[i] = en[i] & ~w_sync;
            w_tgl[i] = w_run[i] & (r_cnt[i] >= r_half[i]);
            w_bnd[i] = ~w_run[i] | w_tgl[i];
            w_acc[i] = cfg_valid & w_ready & (cfg_ch == CW'(i));
        end
    end
    // Divider counters, output levels and shadow-to-active transfer at period boundaries
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_clk  <= '0;
            r_tick <= '0;
            r_pend <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]    <= '0;
                r_half[i]   <= DEFAULT_HALF;
                r_shadow[i] <= DEFAULT_HALF;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]  <= w_bnd[i] ? '0 : r_cnt[i] + 1'b1;
                r_clk[i]  <= w_run[i] & (r_clk[i] ^ w_tgl[i]);
                r_tick[i] <= w_tgl[i];
                if (w_bnd[i] && r_pend[i]) begin
                    r_half[i] <= r_shadow[i];
                    r_pend[i] <= 1'b0;
                end
                if (w_acc[i]) begin
                    r_shadow[i] <= cfg_half;
                    r_pend[i]   <= 1'b1;
                end
            end
        end
    end
    assign cfg_ready = w_ready;
    assign clk_out   = r_clk;
    assign tick      = r_tick;
    assign pending   = r_pend;
endmodule

// File: tb/tb_clk_gen_multi.sv
// tb_clk_gen_multi: table-driven directed bench for clk_gen_multi (NUM_CH=2, DEFAULT_HALF=0).
module tb_clk_gen_multi;
    logic        clk_in = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  en = 2'b00;
    logic        cfg_valid = 1'b0;
    logic [0:0]  cfg_ch = 1'b0;
    logic [15:0] cfg_half = 16'd0;
    logic        cfg_ready;
    logic [1:0]  clk_out, tick, pending;
`ifdef CLK_GEN_SYNC_EN
    logic        sync_restart = 1'b0;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    clk_gen_multi #(.NUM_CH(2), .WIDTH(16), .DEFAULT_HALF(16'd0)) dut (
        .clk_in(clk_in),
        .rst(rst),
        .en(en),
        .cfg_valid(cfg_valid),
        .cfg_ch(cfg_ch),
        .cfg_half(cfg_half),
`ifdef CLK_GEN_SYNC_EN
        .sync_restart(sync_restart),
`endif
        .cfg_ready(cfg_ready),
        .clk_out(clk_out),
        .tick(tick),
        .pending(pending)
    );

    typedef struct packed {
        logic [1:0]  en;
        logic        v;
        logic        ch;
        logic [15:0] half;
        logic        rdy;
        logic [1:0]  clk;
        logic [1:0]  tck;
        logic [1:0]  pnd;
    } vec_t;

    vec_t vt [23];

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        // en, valid, ch, half, ready(before edge), clk_out, tick, pending (after edge)
        vt[0]  = '{2'b01, 1'b0, 1'b0, 16'd0, 1'b1, 2'b01, 2'b01, 2'b00};
        vt[1]  = '{2'b01, 1'b0, 1'b0, 16'd0, 1'b1, 2'b00, 2'b01, 2'b00};
        vt[2]  = '{2'b01, 1'b0, 1'b0, 16'd0, 1'b1, 2'b01, 2'b01, 2'b00};
        vt[3]  = '{2'b01, 1'b0, 1'b0, 16'd0, 1'b1, 2'b00, 2'b01, 2'b00};
        vt[4]  = '{2'b01, 1'b1, 1'b0, 16'd2, 1'b1, 2'b01, 2'b01, 2'b01};
        vt[5]  = '{2'b01, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00, 2'b01, 2'b00};
        vt[6]  = '{2'b01, 1'b0, 1'b0, 16'd0, 1'b1, 2'b00, 2'b00, 2'b00};
        vt[7]  = '{2'b01, 1'b0, 1'b0, 16'd0, 1'b1, 2'b00, 2'b00, 2'b00};
        vt[8]  = '{2'b01, 1'b1, 1'b0, 16'd4, 1'b1, 2'b01, 2'b01, 2'b01};
        vt[9]  = '{2'b01, 1'b1, 1'b0, 16'd7, 1'b0, 2'b01, 2'b00, 2'b01};
        vt[10] = '{2'b01, 1'b1, 1'b0, 16'd7, 1'b0, 2'b01, 2'b00, 2'b01};
        vt[11] = '{2'b01, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00, 2'b01, 2'b00};
        vt[12] = '{2'b01, 1'b1, 1'b1, 16'd1, 1'b1, 2'b00, 2'b00, 2'b10};
        vt[13] = '{2'b01, 1'b0, 1'b0, 16'd0, 1'b1, 2'b00, 2'b00, 2'b00};
        vt[14] = '{2'b01, 1'b0, 1'b0, 16'd0, 1'b1, 2'b00, 2'b00, 2'b00};
        vt[15] = '{2'b01, 1'b0, 1'b0, 16'd0, 1'b1, 2'b00, 2'b00, 2'b00};
        vt[16] = '{2'b01, 1'b0, 1'b0, 16'd0, 1'b1, 2'b01, 2'b01, 2'b00};
        vt[17] = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b1, 2'b01, 2'b00, 2'b00};
        vt[18] = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b1, 2'b11, 2'b10, 2'b00};
        vt[19] = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b1, 2'b11, 2'b00, 2'b00};
        vt[20] = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b1, 2'b01, 2'b10, 2'b00};
        vt[21] = '{2'b11, 1'b0, 1'b0, 16'd0, 1'b1, 2'b00, 2'b01, 2'b00};
        vt[22] = '{2'b10, 1'b0, 1'b0, 16'd0, 1'b1, 2'b10, 2'b10, 2'b00};

        // Asynchronous reset with the clock running
        #2 rst = 1'b1;
        #1;
        chk("reset clk_out", clk_out, 2'b00);
        chk("reset tick", tick, 2'b00);
        chk("reset pending", pending, 2'b00);
        @(posedge clk_in);
        #1 rst = 1'b0;

        // Main table: divide-by-2, shadow updates, held requests, independence
        for (int i = 0; i < 23; i++) begin
            en        = vt[i].en;
            cfg_valid = vt[i].v;
            cfg_ch    = vt[i].ch;
            cfg_half  = vt[i].half;
            #1;
            chk($sformatf("v%0d cfg_ready", i), {1'b0, cfg_ready}, {1'b0, vt[i].rdy});
            @(posedge clk_in);
            #1;
            chk($sformatf("v%0d clk_out", i), clk_out, vt[i].clk);
            chk($sformatf("v%0d tick", i), tick, vt[i].tck);
            chk($sformatf("v%0d pending", i), pending, vt[i].pnd);
        end

        // Reset mid-period with a pending value discards it and restores DEFAULT_HALF
        en = 2'b11;
        cfg_valid = 1'b1;
        cfg_ch = 1'b0;
        cfg_half = 16'd6;
        step();
        cfg_valid = 1'b0;
        chk("pre-reset clk_out", clk_out, 2'b10);
        chk("pre-reset pending", pending, 2'b01);
        #3 rst = 1'b1;
        #1;
        chk("mid-reset clk_out", clk_out, 2'b00);
        chk("mid-reset tick", tick, 2'b00);
        chk("mid-reset pending", pending, 2'b00);
        en = 2'b01;
        @(posedge clk_in);
        #1 rst = 1'b0;
        step();
        chk("post-reset clk_out 1", clk_out, 2'b01);
        chk("post-reset tick 1", tick, 2'b01);
        step();
        chk("post-reset clk_out 2", clk_out, 2'b00);
        chk("post-reset tick 2", tick, 2'b01);
        chk("post-reset pending", pending, 2'b00);

`ifdef CLK_GEN_SYNC_EN
        // Load ch0 half=1, ch1 half=3 while disabled, run, then phase-align
        en = 2'b00;
        cfg_valid = 1'b1;
        cfg_ch = 1'b0;
        cfg_half = 16'd1;
        step();
        chk("sync cfg0 pending", pending, 2'b01);
        cfg_ch = 1'b1;
        cfg_half = 16'd3;
        #1;
        chk("sync cfg1 ready", {1'b0, cfg_ready}, 2'b01);
        step();
        chk("sync cfg1 pending", pending, 2'b10);
        cfg_valid = 1'b0;
        step();
        chk("sync applied pending", pending, 2'b00);
        en = 2'b11;
        step();
        step();
        step();
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        chk("sync clk_out", clk_out, 2'b00);
        chk("sync tick", tick, 2'b00);
        step();
        chk("sync +1 clk_out", clk_out, 2'b00);
        step();
        chk("sync +2 clk_out", clk_out, 2'b01);
        step();
        chk("sync +3 clk_out", clk_out, 2'b01);
        step();
        chk("sync +4 clk_out", clk_out, 2'b10);
        chk("sync +4 tick", tick, 2'b11);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
